// File: rtl/adxl362_spi_cmd_pkg.sv
// Shared definitions for the ADXL362 SPI command sequencer.
//  - Default opcode values and the first unmapped register address.
//  - Sequencer state encoding.
//  - below_limit(): address range test used for write suppression and read masking.
package adxl362_spi_cmd_pkg;

  localparam logic [7:0] DefCmdWrite  = 8'h0A;
  localparam logic [7:0] DefCmdRead   = 8'h0B;
  localparam logic [7:0] DefCmdFifo   = 8'h0D;
  localparam logic [7:0] DefAddrLimit = 8'h40;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StAddrW,
    StWdata,
    StStrobe,
    StAddrR,
    StRfetch,
    StRdata,
    StFifo,
    StDiscard
  } state_e;

  function automatic logic below_limit(logic [7:0] addr, logic [7:0] limit);
    return addr < limit;
  endfunction

endpackage

// File: rtl/adxl362_spi_cmd_if.sv
// Bus between the SPI byte shifter / register file and the command sequencer.
//  slave  : sequencer side (takes cs_n, rx_valid, rx_byte, data_read; drives the rest)
//  master : shifter / register-file side
interface adxl362_spi_cmd_if;
  logic       cs_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] data_read;
  logic [5:0] address;
  logic [7:0] data_write;
  logic       write;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic       cmd_error;
  logic       busy;

  modport slave (
    input  cs_n, rx_valid, rx_byte, data_read,
    output address, data_write, write, tx_byte, tx_load, cmd_error, busy
  );

  modport master (
    output cs_n, rx_valid, rx_byte, data_read,
    input  address, data_write, write, tx_byte, tx_load, cmd_error, busy
  );
endinterface

// File: rtl/adxl362_spi_cmd.sv
// ADXL362 command sequencer: decodes write (0x0A), read (0x0B) and FIFO read (0x0D)
// frames from received SPI bytes, drives the register file with auto-incrementing
// address and returns read bytes to the shifter.
// Ports:
//  clk_16mhz : system clock
//  reset_n   : asynchronous active-low reset
//  bus_io    : slave side of adxl362_spi_cmd_if (cs_n, rx_valid/rx_byte, data_read in;
//              address, data_write, write, tx_byte/tx_load, cmd_error, busy out)
// All outputs are registered.
module adxl362_spi_cmd
  import adxl362_spi_cmd_pkg::*;
#(
  parameter logic [7:0] CmdWrite  = DefCmdWrite,
  parameter logic [7:0] CmdRead   = DefCmdRead,
  parameter logic [7:0] CmdFifo   = DefCmdFifo,
  parameter logic [7:0] AddrLimit = DefAddrLimit
) (
  input logic               clk_16mhz,
  input logic               reset_n,
  adxl362_spi_cmd_if.slave  bus_io
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       incr_q, incr_d;
  logic [7:0] data_write_q, data_write_d;
  logic       write_q, write_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_load_q, tx_load_d;
  logic       cmd_error_q, cmd_error_d;
  logic       busy_q;
  logic       byte_taken;

  // STROBE and RFETCH are one-cycle states that cannot accept a byte.
  assign byte_taken = bus_io.rx_valid && (state_q != StIdle) &&
                      (state_q != StStrobe) && (state_q != StRfetch);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    incr_d       = 1'b0;
    data_write_d = data_write_q;
    write_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    tx_load_d    = 1'b0;
    cmd_error_d  = 1'b0;

    // Increment one cycle after STROBE so address holds while write is high.
    if (incr_q) addr_d = addr_q + 8'd1;

    case (state_q)
      StIdle: begin
        if (!bus_io.cs_n) state_d = StCmd;
      end
      StCmd: begin
        if (bus_io.rx_valid) begin
          if (bus_io.rx_byte == CmdWrite) begin
            state_d = StAddrW;
          end else if (bus_io.rx_byte == CmdRead) begin
            state_d = StAddrR;
          end else if (bus_io.rx_byte == CmdFifo) begin
            state_d   = StFifo;
            tx_byte_d = 8'h00;
            tx_load_d = 1'b1;
          end else begin
            state_d     = StDiscard;
            cmd_error_d = 1'b1;
          end
        end
      end
      StAddrW: begin
        if (bus_io.rx_valid) begin
          addr_d  = bus_io.rx_byte;
          state_d = StWdata;
        end
      end
      StWdata: begin
        if (bus_io.rx_valid) begin
          data_write_d = bus_io.rx_byte;
          state_d      = StStrobe;
        end
      end
      StStrobe: begin
        // The write pulse always completes, even when cs_n has already risen.
        write_d     = below_limit(addr_q, AddrLimit);
        cmd_error_d = bus_io.rx_valid;
        incr_d      = !bus_io.cs_n;
        state_d     = bus_io.cs_n ? StIdle : StWdata;
      end
      StAddrR: begin
        if (bus_io.rx_valid) begin
          addr_d  = bus_io.rx_byte;
          state_d = StRfetch;
        end
      end
      StRfetch: begin
        cmd_error_d = bus_io.rx_valid;
        if (!bus_io.cs_n) begin
          tx_byte_d = below_limit(addr_q, AddrLimit) ? bus_io.data_read : 8'h00;
          tx_load_d = 1'b1;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (bus_io.rx_valid) begin
          addr_d  = addr_q + 8'd1;
          state_d = StRfetch;
        end
      end
      StFifo: begin
        if (bus_io.rx_valid) begin
          tx_byte_d = 8'h00;
          tx_load_d = 1'b1;
        end
      end
      StDiscard: begin
        state_d = StDiscard;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A byte arriving with cs_n high is processed first; IDLE follows a cycle later.
    if (bus_io.cs_n && (state_q != StStrobe) && !byte_taken) state_d = StIdle;
  end

  always_ff @(posedge clk_16mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= 8'h00;
      incr_q       <= 1'b0;
      data_write_q <= 8'h00;
      write_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
      tx_load_q    <= 1'b0;
      cmd_error_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      incr_q       <= incr_d;
      data_write_q <= data_write_d;
      write_q      <= write_d;
      tx_byte_q    <= tx_byte_d;
      tx_load_q    <= tx_load_d;
      cmd_error_q  <= cmd_error_d;
      busy_q       <= (state_d != StIdle);
    end
  end

  assign bus_io.address    = addr_q[5:0];
  assign bus_io.data_write = data_write_q;
  assign bus_io.write      = write_q;
  assign bus_io.tx_byte    = tx_byte_q;
  assign bus_io.tx_load    = tx_load_q;
  assign bus_io.cmd_error  = cmd_error_q;
  assign bus_io.busy       = busy_q;

endmodule
